// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset/exception vectors and decode PC-source encodings.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] EXC_PC   = 32'hBFC00380;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10
  } pcsrc_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: exception > eret > taken redirect (live or pending) > PC+4.
module fetch_next_pc
  import cpu_defs::*;
(
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_j_target,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_pend_target,
  input  logic        i_ex,
  input  logic        i_eret,
  input  logic        i_handoff,
  input  logic        i_live_sel,
  input  logic        i_jsrc,
  input  logic        i_ds_pending,
  input  logic [1:0]  i_pcsrc,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_live_target,
  output logic        o_live_taken
);

  pcsrc_e      w_pcsrc;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_seq_pc;

  assign w_pcsrc  = pcsrc_e'(i_pcsrc);
  assign w_seq_pc = i_if_pc + 32'd4;

  // Decode-side redirect as currently presented by decode
  always_comb begin
    o_live_taken  = 1'b0;
    o_live_target = w_seq_pc;
    if (w_pcsrc == PCSRC_BR) begin
      o_live_taken  = 1'b1;
      o_live_target = i_br_target;
    end else if (w_pcsrc == PCSRC_J) begin
      o_live_taken  = 1'b1;
      o_live_target = i_jsrc ? i_jr_target : i_j_target;
    end
  end

  // Redirect only steers the request that hands the delay slot to decode
  always_comb begin
    w_taken  = i_live_sel ? o_live_taken  : i_ds_pending;
    w_target = i_live_sel ? o_live_target : i_pend_target;
    if (i_ex)
      o_next_pc = EXC_PC;
    else if (i_eret)
      o_next_pc = i_epc;
    else if (i_handoff && w_taken)
      o_next_pc = w_target;
    else
      o_next_pc = w_seq_pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, SRAM request, stall buffer, IF/ID registers.
// Optional macro FETCH_ADEL_EN: suppress misaligned fetches and hand a nop with AdEL set.
module fetch_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        JSrc,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] J_target_ID,
  input  logic [31:0] JR_target_ID,
  input  logic [31:0] Br_target_ID,
  input  logic        is_j_or_br_ID,
  input  logic        decode_stage_valid,
  input  logic        de_to_exe_valid,
  input  logic        exe_allowin,
  input  logic        decode_allowin,
  input  logic        ex_int_handling,
  input  logic        eret_handling,
  input  logic [31:0] epc,
  output logic        fe_to_de_valid,
  output logic [31:0] Inst_IF_ID,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] PC_add_4_IF_ID,
  output logic        PC_AdEL_IF_ID,
  output logic        DSI_IF_ID
);

  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic [31:0] r_inst_buf;
  logic        r_buf_valid;
  logic        r_req_d;
  logic        r_ds_pending;
  logic [31:0] r_pend_target;

  logic        w_flush;
  logic        w_if_allowin;
  logic        w_handoff;
  logic        w_req;
  logic        w_live_sel;
  logic        w_live_taken;
  logic [31:0] w_live_target;
  logic [31:0] w_next_pc;
  logic [31:0] w_inst;
  logic        w_if_adel;

  assign w_flush      = ex_int_handling || eret_handling;
  assign w_if_allowin = !r_if_valid || decode_allowin;
  assign w_handoff    = r_if_valid && decode_allowin && !w_flush;
  assign w_req        = w_if_allowin || w_flush;
  assign w_live_sel   = decode_stage_valid && (PCSrc != 2'b00);

  fetch_next_pc u_next_pc (
    .i_if_pc       (r_if_pc),
    .i_epc         (epc),
    .i_br_target   (Br_target_ID),
    .i_j_target    (J_target_ID),
    .i_jr_target   (JR_target_ID),
    .i_pend_target (r_pend_target),
    .i_ex          (ex_int_handling),
    .i_eret        (eret_handling),
    .i_handoff     (w_handoff),
    .i_live_sel    (w_live_sel),
    .i_jsrc        (JSrc),
    .i_ds_pending  (r_ds_pending),
    .i_pcsrc       (PCSrc),
    .o_next_pc     (w_next_pc),
    .o_live_target (w_live_target),
    .o_live_taken  (w_live_taken)
  );

  assign fe_to_de_valid = r_if_valid;
  assign inst_sram_addr = w_next_pc;

`ifdef FETCH_ADEL_EN
  assign w_if_adel    = (r_if_pc[1:0] != 2'b00);
  assign inst_sram_en = w_req && (w_next_pc[1:0] == 2'b00);
  assign w_inst       = w_if_adel ? '0 : (r_buf_valid ? r_inst_buf : inst_sram_rdata);
`else
  assign w_if_adel    = 1'b0;
  assign inst_sram_en = w_req;
  assign w_inst       = r_buf_valid ? r_inst_buf : inst_sram_rdata;
`endif

  // IF state: PC/valid, response buffer across stalls, pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_pc       <= RESET_PC - 32'd4;
      r_if_valid    <= 1'b0;
      r_inst_buf    <= '0;
      r_buf_valid   <= 1'b0;
      r_req_d       <= 1'b0;
      r_ds_pending  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      if (w_req) begin
        r_if_pc    <= w_next_pc;
        r_if_valid <= 1'b1;
      end else if (w_handoff) begin
        r_if_valid <= 1'b0;
      end
      r_req_d <= w_req;

      if (w_flush || w_handoff) begin
        r_buf_valid <= 1'b0;
      end else if (r_req_d) begin
        r_buf_valid <= 1'b1;
        r_inst_buf  <= inst_sram_rdata;
      end

      // A branch leaving decode before its delay slot was handed keeps its
      // redirect here until that delay slot is handed over.
      if (w_flush || w_handoff) begin
        r_ds_pending <= 1'b0;
      end else if (de_to_exe_valid && exe_allowin && w_live_sel && w_live_taken) begin
        r_ds_pending  <= 1'b1;
        r_pend_target <= w_live_target;
      end
    end
  end

  // IF/ID registers load on handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Inst_IF_ID     <= '0;
      PC_IF_ID       <= '0;
      PC_add_4_IF_ID <= '0;
      PC_AdEL_IF_ID  <= 1'b0;
      DSI_IF_ID      <= 1'b0;
    end else if (w_handoff) begin
      Inst_IF_ID     <= w_inst;
      PC_IF_ID       <= r_if_pc;
      PC_add_4_IF_ID <= r_if_pc + 32'd4;
      PC_AdEL_IF_ID  <= w_if_adel;
      DSI_IF_ID      <= (decode_stage_valid && is_j_or_br_ID) || r_ds_pending;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        JSrc;
  logic [1:0]  PCSrc;
  logic [31:0] J_target_ID, JR_target_ID, Br_target_ID;
  logic        is_j_or_br_ID, decode_stage_valid, de_to_exe_valid, exe_allowin, decode_allowin;
  logic        ex_int_handling, eret_handling;
  logic [31:0] epc;
  logic        fe_to_de_valid;
  logic [31:0] Inst_IF_ID, PC_IF_ID, PC_add_4_IF_ID;
  logic        PC_AdEL_IF_ID, DSI_IF_ID;

  int checks = 0;
  int errors = 0;

  logic        m_en;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .JSrc(JSrc), .PCSrc(PCSrc),
    .J_target_ID(J_target_ID), .JR_target_ID(JR_target_ID), .Br_target_ID(Br_target_ID),
    .is_j_or_br_ID(is_j_or_br_ID), .decode_stage_valid(decode_stage_valid),
    .de_to_exe_valid(de_to_exe_valid), .exe_allowin(exe_allowin), .decode_allowin(decode_allowin),
    .ex_int_handling(ex_int_handling), .eret_handling(eret_handling), .epc(epc),
    .fe_to_de_valid(fe_to_de_valid), .Inst_IF_ID(Inst_IF_ID), .PC_IF_ID(PC_IF_ID),
    .PC_add_4_IF_ID(PC_add_4_IF_ID), .PC_AdEL_IF_ID(PC_AdEL_IF_ID), .DSI_IF_ID(DSI_IF_ID)
  );

  // SRAM contents: one marked word, every other address returns its inverse
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h80000100) return 32'h24020005;
    return ~a;
  endfunction

  // 1-cycle SRAM; request latched mid-cycle, garbage when no request was made
  always @(negedge clk) begin
    m_en   <= inst_sram_en;
    m_addr <= inst_sram_addr;
  end
  always @(posedge clk) inst_sram_rdata <= m_en ? inst_of(m_addr) : 32'hDEADBEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode();
    JSrc = 1'b0; PCSrc = 2'b00; is_j_or_br_ID = 1'b0; decode_stage_valid = 1'b0;
    de_to_exe_valid = 1'b0; exe_allowin = 1'b1; decode_allowin = 1'b1;
    ex_int_handling = 1'b0; eret_handling = 1'b0;
  endtask

  task automatic do_eret(input logic [31:0] a);
    epc = a; eret_handling = 1'b1;
    step();
    eret_handling = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (fe_to_de_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", fe_to_de_valid); end
    checks++; if (PC_IF_ID !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", PC_IF_ID); end
    checks++; if (Inst_IF_ID !== 32'h0) begin errors++; $display("FAIL rst_inst got %h want 0", Inst_IF_ID); end
    checks++; if (PC_add_4_IF_ID !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", PC_add_4_IF_ID); end
    checks++; if (DSI_IF_ID !== 1'b0) begin errors++; $display("FAIL rst_dsi got %b want 0", DSI_IF_ID); end
    rst = 1'b0;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC00000) begin errors++; $display("FAIL first_req got en=%b %h want 1 bfc00000", inst_sram_en, inst_sram_addr); end
    step();
    checks++; if (fe_to_de_valid !== 1'b1) begin errors++; $display("FAIL start_valid got %b want 1", fe_to_de_valid); end
    checks++; if (inst_sram_addr !== 32'hBFC00004) begin errors++; $display("FAIL second_req got %h want bfc00004", inst_sram_addr); end
    step();
    checks++; if (PC_IF_ID !== 32'hBFC00000) begin errors++; $display("FAIL start_pc got %h want bfc00000", PC_IF_ID); end
    checks++; if (PC_add_4_IF_ID !== 32'hBFC00004) begin errors++; $display("FAIL start_pc4 got %h want bfc00004", PC_add_4_IF_ID); end
    checks++; if (Inst_IF_ID !== 32'h403FFFFF) begin errors++; $display("FAIL start_inst got %h want 403fffff", Inst_IF_ID); end
  endtask

  task automatic test_branch();
    do_eret(32'hBFC00010);
    step();
    decode_stage_valid = 1'b1; is_j_or_br_ID = 1'b1; PCSrc = 2'b01;
    Br_target_ID = 32'hBFC00100; de_to_exe_valid = 1'b1;
    #1;
    checks++; if (inst_sram_addr !== 32'hBFC00100) begin errors++; $display("FAIL br_req got %h want bfc00100", inst_sram_addr); end
    step();
    clear_decode();
    checks++; if (PC_IF_ID !== 32'hBFC00014 || DSI_IF_ID !== 1'b1) begin errors++; $display("FAIL br_slot got pc=%h dsi=%b want bfc00014 1", PC_IF_ID, DSI_IF_ID); end
    #1;
    checks++; if (inst_sram_addr !== 32'hBFC00104) begin errors++; $display("FAIL br_after got %h want bfc00104", inst_sram_addr); end
    step();
    checks++; if (PC_IF_ID !== 32'hBFC00100 || DSI_IF_ID !== 1'b0) begin errors++; $display("FAIL br_target got pc=%h dsi=%b want bfc00100 0", PC_IF_ID, DSI_IF_ID); end
  endtask

  task automatic test_jump();
    do_eret(32'h80000300);
    step();
    decode_stage_valid = 1'b1; is_j_or_br_ID = 1'b1; PCSrc = 2'b10; JSrc = 1'b1;
    JR_target_ID = 32'h80000500; J_target_ID = 32'h80000600;
    #1;
    checks++; if (inst_sram_addr !== 32'h80000500) begin errors++; $display("FAIL jr_req got %h want 80000500", inst_sram_addr); end
    JSrc = 1'b0;
    #1;
    checks++; if (inst_sram_addr !== 32'h80000600) begin errors++; $display("FAIL j_req got %h want 80000600", inst_sram_addr); end
    PCSrc = 2'b11;
    #1;
    checks++; if (inst_sram_addr !== 32'h80000308) begin errors++; $display("FAIL pcsrc11_req got %h want 80000308", inst_sram_addr); end
    clear_decode();
  endtask

  task automatic test_pending();
    do_eret(32'h80000000);
    step();
    decode_allowin = 1'b0; decode_stage_valid = 1'b1; is_j_or_br_ID = 1'b1;
    PCSrc = 2'b01; Br_target_ID = 32'h80000400; de_to_exe_valid = 1'b1;
    #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL pend_stall_en got %b want 0", inst_sram_en); end
    step();
    clear_decode();
    #1;
    checks++; if (inst_sram_addr !== 32'h80000400) begin errors++; $display("FAIL pend_req got %h want 80000400", inst_sram_addr); end
    step();
    checks++; if (PC_IF_ID !== 32'h80000004 || DSI_IF_ID !== 1'b1) begin errors++; $display("FAIL pend_slot got pc=%h dsi=%b want 80000004 1", PC_IF_ID, DSI_IF_ID); end
    checks++; if (Inst_IF_ID !== 32'h7FFFFFFB) begin errors++; $display("FAIL pend_inst got %h want 7ffffffb", Inst_IF_ID); end
    checks++; if (inst_sram_addr !== 32'h80000404) begin errors++; $display("FAIL pend_consumed got %h want 80000404", inst_sram_addr); end
    step();
    checks++; if (PC_IF_ID !== 32'h80000400 || DSI_IF_ID !== 1'b0) begin errors++; $display("FAIL pend_target got pc=%h dsi=%b want 80000400 0", PC_IF_ID, DSI_IF_ID); end
  endtask

  task automatic test_stall();
    do_eret(32'h80000100);
    decode_allowin = 1'b0;
    #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_en0 got %b want 0", inst_sram_en); end
    step();
    checks++; if (inst_sram_en !== 1'b0 || fe_to_de_valid !== 1'b1) begin errors++; $display("FAIL stall_en1 got en=%b v=%b want 0 1", inst_sram_en, fe_to_de_valid); end
    step();
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_en2 got %b want 0", inst_sram_en); end
    decode_allowin = 1'b1;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h80000104) begin errors++; $display("FAIL stall_rel got en=%b %h want 1 80000104", inst_sram_en, inst_sram_addr); end
    step();
    checks++; if (Inst_IF_ID !== 32'h24020005 || PC_IF_ID !== 32'h80000100) begin errors++; $display("FAIL stall_hand got %h pc=%h want 24020005 80000100", Inst_IF_ID, PC_IF_ID); end
    step();
    checks++; if (PC_IF_ID !== 32'h80000104 || Inst_IF_ID !== 32'h7FFFFEFB) begin errors++; $display("FAIL stall_next got pc=%h %h want 80000104 7ffffefb", PC_IF_ID, Inst_IF_ID); end
  endtask

  task automatic test_exc_stall();
    do_eret(32'h80000200);
    step();
    decode_allowin = 1'b0;
    step();
    ex_int_handling = 1'b1; decode_allowin = 1'b1;
    #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC00380) begin errors++; $display("FAIL exc_req got en=%b %h want 1 bfc00380", inst_sram_en, inst_sram_addr); end
    step();
    ex_int_handling = 1'b0;
    checks++; if (PC_IF_ID !== 32'h80000200) begin errors++; $display("FAIL exc_nohand got %h want 80000200", PC_IF_ID); end
    step();
    checks++; if (PC_IF_ID !== 32'hBFC00380 || Inst_IF_ID !== 32'h403FFC7F) begin errors++; $display("FAIL exc_vec got pc=%h %h want bfc00380 403ffc7f", PC_IF_ID, Inst_IF_ID); end
  endtask

  task automatic test_eret();
    epc = 32'h80001234; eret_handling = 1'b1;
    decode_stage_valid = 1'b1; is_j_or_br_ID = 1'b1; PCSrc = 2'b10; JSrc = 1'b0;
    J_target_ID = 32'h80005000; de_to_exe_valid = 1'b1;
    #1;
    checks++; if (inst_sram_addr !== 32'h80001234) begin errors++; $display("FAIL eret_req got %h want 80001234", inst_sram_addr); end
    step();
    clear_decode();
    #1;
    checks++; if (inst_sram_addr !== 32'h80001238) begin errors++; $display("FAIL eret_seq got %h want 80001238", inst_sram_addr); end
    step();
    checks++; if (PC_IF_ID !== 32'h80001234 || DSI_IF_ID !== 1'b0) begin errors++; $display("FAIL eret_hand got pc=%h dsi=%b want 80001234 0", PC_IF_ID, DSI_IF_ID); end
  endtask

  task automatic test_adel();
    epc = 32'h80000002; eret_handling = 1'b1;
    #1;
`ifdef FETCH_ADEL_EN
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL adel_en got %b want 0", inst_sram_en); end
`else
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h80000002) begin errors++; $display("FAIL adel_raw got en=%b %h want 1 80000002", inst_sram_en, inst_sram_addr); end
`endif
    step();
    eret_handling = 1'b0;
    step();
    checks++; if (PC_IF_ID !== 32'h80000002) begin errors++; $display("FAIL adel_pc got %h want 80000002", PC_IF_ID); end
`ifdef FETCH_ADEL_EN
    checks++; if (PC_AdEL_IF_ID !== 1'b1 || Inst_IF_ID !== 32'h0) begin errors++; $display("FAIL adel_hand got adel=%b %h want 1 0", PC_AdEL_IF_ID, Inst_IF_ID); end
`else
    checks++; if (PC_AdEL_IF_ID !== 1'b0 || Inst_IF_ID !== 32'h7FFFFFFD) begin errors++; $display("FAIL adel_hand got adel=%b %h want 0 7ffffffd", PC_AdEL_IF_ID, Inst_IF_ID); end
`endif
  endtask

  task automatic test_async_reset();
    step();
    rst = 1'b1;
    #1;
    checks++; if (fe_to_de_valid !== 1'b0 || PC_IF_ID !== 32'h0) begin errors++; $display("FAIL arst got v=%b pc=%h want 0 0", fe_to_de_valid, PC_IF_ID); end
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (PC_IF_ID !== 32'hBFC00000 || Inst_IF_ID !== 32'h403FFFFF) begin errors++; $display("FAIL arst_restart got pc=%h %h want bfc00000 403fffff", PC_IF_ID, Inst_IF_ID); end
  endtask

  initial begin
    rst = 1'b1;
    epc = '0; J_target_ID = '0; JR_target_ID = '0; Br_target_ID = '0;
    clear_decode();
    test_reset();
    test_branch();
    test_jump();
    test_pending();
    test_stall();
    test_exc_stall();
    test_eret();
    test_adel();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
